bcd_score_keeper: RTL and testbench

Parametrised score/length tracker for the snake game: sits between the collision path and the display path, replacing the fixed-width score tracker plus its separate posedge detector. It edge-detects raw collision levels internally and keeps snake length, a DIGITS-wide BCD score and an optional high score. It also runs the PLAY/OVER/WON game-state machine that feeds the image generator and the seven-segment toggler.

---
 rtl/bcd_score_keeper.sv | 140 ++++++++++++++
 tb/tb_bcd_score_keeper.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_keeper.sv
// Snake-game score/length tracker: internal collision edge detect, BCD score, PLAY/OVER/WON FSM.
// Optional high-score tracking is enabled by defining SCORE_HIGH_EN.
module bcd_score_keeper #(
    parameter int DIGITS      = 3,
    parameter int LEN_W       = 8,
    parameter int INIT_LENGTH = 2,
    parameter int MAX_LENGTH  = 60
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                good_coll_i,
    input  logic                bad_coll_i,
    output logic [LEN_W-1:0]    curr_length,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic [4*DIGITS-1:0] high_bcd,
    output logic                new_high,
    output logic                game_over,
    output logic                game_won
);

    localparam int SW = 4 * DIGITS;

    typedef enum logic [1:0] {PLAY, OVER, WON} state_t;

    state_t           state_q, state_d;
    logic             g_q, b_q;
    logic             g_pulse, b_pulse;
    logic [LEN_W-1:0] len_q, len_d;
    logic [SW-1:0]    score_q, score_d;

    // Ripple-carry BCD increment that holds at all-9s instead of wrapping.
    function automatic logic [SW-1:0] bcd_inc_sat(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        logic          all9;
        r     = v;
        carry = 1'b1;
        all9  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return all9 ? v : r;
    endfunction

    assign g_pulse = good_coll_i & ~g_q;
    assign b_pulse = bad_coll_i & ~b_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        score_d = score_q;
        if (state_q == PLAY) begin
            if (b_pulse) begin
                state_d = OVER;
            end else if (g_pulse) begin
                len_d   = len_q + 1'b1;
                score_d = bcd_inc_sat(score_q);
                if (len_d == LEN_W'(MAX_LENGTH)) state_d = WON;
            end
        end
    end

    // clr re-arms the edge detectors on the live inputs so a held level is not a new pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLAY;
            len_q   <= LEN_W'(INIT_LENGTH);
            score_q <= '0;
            g_q     <= 1'b0;
            b_q     <= 1'b0;
        end else if (clr) begin
            state_q <= PLAY;
            len_q   <= LEN_W'(INIT_LENGTH);
            score_q <= '0;
            g_q     <= good_coll_i;
            b_q     <= bad_coll_i;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            score_q <= score_d;
            g_q     <= good_coll_i;
            b_q     <= bad_coll_i;
        end
    end

    assign curr_length = len_q;
    assign score_bcd   = score_q;
    assign game_over   = (state_q != PLAY);
    assign game_won    = (state_q == WON);

`ifdef SCORE_HIGH_EN
    logic [SW-1:0] high_q;
    logic          new_high_q;
    logic          finish;

    function automatic logic bcd_gt(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt   = (a[4*i +: 4] > b[4*i +: 4]);
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    assign finish = (state_q == PLAY) && (state_d != PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            high_q     <= '0;
            new_high_q <= 1'b0;
        end else if (clr) begin
            new_high_q <= 1'b0;
        end else if (finish && bcd_gt(score_d, high_q)) begin
            high_q     <= score_d;
            new_high_q <= 1'b1;
        end
    end

    assign high_bcd = high_q;
    assign new_high = new_high_q;
`else
    assign high_bcd = '0;
    assign new_high = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Self-checking bench for bcd_score_keeper: directed scenarios plus randomized play against a numeric model.
module tb_bcd_score_keeper;

    localparam int DIGITS      = 3;
    localparam int LEN_W       = 8;
    localparam int INIT_LENGTH = 2;
    localparam int MAX_LENGTH  = 60;
    localparam int SCORE_MAX   = 10 ** DIGITS - 1;
`ifdef SCORE_HIGH_EN
    localparam bit HE = 1'b1;
`else
    localparam bit HE = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clr = 1'b0;
    logic                good = 1'b0;
    logic                bad = 1'b0;
    logic [LEN_W-1:0]    curr_length;
    logic [4*DIGITS-1:0] score_bcd, high_bcd;
    logic                new_high, game_over, game_won;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Model state: 0 playing, 1 lost, 2 won; score derived from length.
    int m_state = 0;
    int m_len = INIT_LENGTH;
    int m_high = 0;
    int m_nh = 0;
    int m_gprev = 0;
    int m_bprev = 0;

    bcd_score_keeper #(
        .DIGITS(DIGITS), .LEN_W(LEN_W), .INIT_LENGTH(INIT_LENGTH), .MAX_LENGTH(MAX_LENGTH)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .good_coll_i(good), .bad_coll_i(bad),
        .curr_length(curr_length), .score_bcd(score_bcd), .high_bcd(high_bcd),
        .new_high(new_high), .game_over(game_over), .game_won(game_won)
    );

    always #5 clk = ~clk;

    function automatic int score_of(input int len);
        int s;
        s = len - INIT_LENGTH;
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic m_finish();
        int s;
        s = score_of(m_len);
        if (HE && s > m_high) begin
            m_high = s;
            m_nh = 1;
        end
    endtask

    always @(posedge clk) begin
        int gp, bp;
        if (rst) begin
            m_state = 0; m_len = INIT_LENGTH; m_high = 0; m_nh = 0;
            m_gprev = 0; m_bprev = 0;
        end else if (clr) begin
            m_state = 0; m_len = INIT_LENGTH; m_nh = 0;
            m_gprev = good; m_bprev = bad;
        end else begin
            gp = (good && !m_gprev) ? 1 : 0;
            bp = (bad && !m_bprev) ? 1 : 0;
            if (m_state == 0) begin
                if (bp != 0) begin
                    m_state = 1;
                    m_finish();
                end else if (gp != 0) begin
                    m_len++;
                    if (m_len == MAX_LENGTH) begin
                        m_state = 2;
                        m_finish();
                    end
                end
            end
            m_gprev = good;
            m_bprev = bad;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("len", 32'(curr_length), 32'(m_len));
            check("score", 32'(score_bcd), 32'(to_bcd(score_of(m_len))));
            check("high", 32'(high_bcd), 32'(to_bcd(m_high)));
            check("new_high", 32'(new_high), 32'(m_nh));
            check("game_over", 32'(game_over), 32'(m_state != 0));
            check("game_won", 32'(game_won), 32'(m_state == 2));
        end
    end

    task automatic pulse_g();
        @(negedge clk) good = 1'b1;
        @(negedge clk) good = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_b();
        @(negedge clk) bad = 1'b1;
        @(negedge clk) bad = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_len", 32'(curr_length), 32'd2);
        check("rst_score", 32'(score_bcd), 32'h000);
        check("rst_high", 32'(high_bcd), 32'h000);
        check("rst_over", 32'({game_over, game_won, new_high}), 32'd0);

        // Held level counts once.
        good = 1'b1;
        repeat (10) @(negedge clk);
        good = 1'b0;
        @(negedge clk);
        check("hold_len", 32'(curr_length), 32'd3);
        check("hold_score", 32'(score_bcd), 32'h001);

        repeat (8) pulse_g();
        check("score9", 32'(score_bcd), 32'h009);
        pulse_g();
        check("carry_score", 32'(score_bcd), 32'h010);
        check("carry_len", 32'(curr_length), 32'd12);

        // Simultaneous good and bad: bad wins.
        @(negedge clk) begin good = 1'b1; bad = 1'b1; end
        @(negedge clk) begin good = 1'b0; bad = 1'b0; end
        @(negedge clk);
        check("both_over", 32'({game_over, game_won}), 32'b10);
        check("both_len", 32'(curr_length), 32'd12);
        check("g1_high", 32'(high_bcd), HE ? 32'h010 : 32'h000);
        check("g1_newhigh", 32'(new_high), 32'(HE));
        pulse_g();
        pulse_b();
        check("over_frozen", 32'(curr_length), 32'd12);

        // clr while good held high.
        @(negedge clk) begin good = 1'b1; clr = 1'b1; end
        @(negedge clk) clr = 1'b0;
        repeat (3) @(negedge clk);
        check("clr_score", 32'(score_bcd), 32'h000);
        check("clr_state", 32'({game_over, new_high}), 32'd0);
        check("clr_high", 32'(high_bcd), HE ? 32'h010 : 32'h000);
        @(negedge clk) good = 1'b0;
        pulse_g();
        check("clr_rearm", 32'(score_bcd), 32'h001);
        pulse_b();
        check("g2_high", 32'(high_bcd), HE ? 32'h010 : 32'h000);
        check("g2_newhigh", 32'(new_high), 32'd0);

        // Win at MAX_LENGTH.
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        repeat (MAX_LENGTH - INIT_LENGTH) pulse_g();
        check("win_len", 32'(curr_length), 32'd60);
        check("win_flags", 32'({game_over, game_won}), 32'b11);
        check("win_score", 32'(score_bcd), 32'h058);
        check("win_high", 32'(high_bcd), HE ? 32'h058 : 32'h000);
        pulse_g();
        check("win_frozen", 32'(curr_length), 32'd60);

        // rst beats clr and clears the high score.
        @(negedge clk) begin rst = 1'b1; clr = 1'b1; end
        @(negedge clk) begin rst = 1'b0; clr = 1'b0; end
        @(negedge clk);
        check("rstclr_high", 32'(high_bcd), 32'h000);
        check("rstclr_len", 32'(curr_length), 32'd2);

        // Randomized play: frequent losses, then long games that can reach a win.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            good = 1'($urandom_range(0, 1));
            if (i < 1500) begin
                bad = ($urandom_range(0, 15) == 0);
                clr = ($urandom_range(0, 59) == 0);
                rst = ($urandom_range(0, 499) == 0);
            end else begin
                bad = ($urandom_range(0, 399) == 0);
                clr = ($urandom_range(0, 299) == 0);
                rst = 1'b0;
            end
        end
        @(negedge clk) begin good = 1'b0; bad = 1'b0; clr = 1'b0; rst = 1'b0; end
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
